// File: rtl/serial_out_arbiter_if.sv
// Frame request/acknowledge bundle between the display drivers and serial_out_arbiter.
// master: driver side (segment and LED drivers); slave: the arbiter.
interface serial_out_arbiter_if #(
  parameter int unsigned SEG_BITS = 64,
  parameter int unsigned LED_BITS = 16
);
  logic                seg_req;
  logic [SEG_BITS-1:0] seg_data;
  logic                seg_ack;
  logic                led_req;
  logic [LED_BITS-1:0] led_data;
  logic                led_ack;
  logic                busy;

  modport master (
    output seg_req, seg_data, led_req, led_data,
    input  seg_ack, led_ack, busy
  );

  modport slave (
    input  seg_req, seg_data, led_req, led_data,
    output seg_ack, led_ack, busy
  );
endinterface

// File: rtl/serial_out_arbiter.sv
// Shared serial shift engine for the 7-segment and LED shift-register chains.
// Arbitrates frame requests from both drivers and shifts one frame at a time, MSB first.
// Optional macro SERIAL_ARB_SEG_PRIORITY_EN: fixed priority (SEG always wins a tie);
// when undefined, ties are resolved round-robin.
module serial_out_arbiter #(
  parameter int unsigned DIV      = 2,
  parameter int unsigned SEG_BITS = 64,
  parameter int unsigned LED_BITS = 16
) (
  input  logic                 clk_100mhz,
  input  logic                 rst,
  serial_out_arbiter_if.slave  bus,
  output logic                 SEGCLK,
  output logic                 SEGDT,
  output logic                 SEGEN,
  output logic                 SEGCLR,
  output logic                 LEDCLK,
  output logic                 LEDDT,
  output logic                 LEDEN,
  output logic                 LEDCLR
);

  localparam int unsigned DivW = $clog2(2 * DIV) + 1;
  localparam int unsigned BitW = $clog2(SEG_BITS) + 1;

  localparam logic [DivW-1:0] BitEnd   = DivW'(2 * DIV - 1);
  localparam logic [DivW-1:0] LatchEnd = DivW'(DIV - 1);
  localparam logic [DivW-1:0] DivHalf  = DivW'(DIV);
  localparam logic [BitW-1:0] SegLast  = BitW'(SEG_BITS - 1);
  localparam logic [BitW-1:0] LedLast  = BitW'(LED_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StLatch} state_e;

  state_e              state_q, state_d;
  logic                act_led_q, act_led_d;   // channel being served (1 = LED)
  logic                last_led_q, last_led_d; // channel served last (1 = LED)
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [SEG_BITS-1:0] shreg_q, shreg_d;

  logic seg_clk_q, seg_dt_q, seg_en_q, led_clk_q, led_dt_q, led_en_q, clr_q;
  logic seg_clk_d, seg_dt_d, seg_en_d, led_clk_d, led_dt_d, led_en_d;
  logic seg_ack_q, led_ack_q, busy_q;
  logic seg_ack_d, led_ack_d, busy_d;
  logic pick_led;

  // Arbitration winner for the current IDLE cycle.
`ifdef SERIAL_ARB_SEG_PRIORITY_EN
  assign pick_led = bus.led_req && !bus.seg_req;
`else
  assign pick_led = bus.led_req && (!bus.seg_req || !last_led_q);
`endif

  // Next-state logic: arbitration, frame load, bit timing and latch pulse.
  always_comb begin
    state_d    = state_q;
    act_led_d  = act_led_q;
    last_led_d = last_led_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (bus.seg_req || bus.led_req) begin
          state_d   = StLoad;
          act_led_d = pick_led;
        end
      end
      StLoad: begin
        // LED frame is left-aligned so both channels shift out of the same MSB.
        shreg_d = act_led_q ? {bus.led_data, {(SEG_BITS - LED_BITS){1'b0}}} : bus.seg_data;
        div_d   = '0;
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == BitEnd) begin
          div_d   = '0;
          shreg_d = {shreg_q[SEG_BITS-2:0], 1'b0};
          if (bit_q == (act_led_q ? LedLast : SegLast)) begin
            state_d = StLatch;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLatch: begin
        if (div_q == LatchEnd) begin
          div_d      = '0;
          state_d    = StIdle;
          last_led_d = act_led_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin/ack values derived from next state so the registered pins line up with state_q.
  always_comb begin
    seg_clk_d = 1'b0;
    seg_dt_d  = 1'b0;
    seg_en_d  = 1'b0;
    led_clk_d = 1'b0;
    led_dt_d  = 1'b0;
    led_en_d  = 1'b0;
    if (state_d == StShift) begin
      seg_clk_d = !act_led_d && (div_d >= DivHalf);
      seg_dt_d  = !act_led_d && shreg_d[SEG_BITS-1];
      led_clk_d = act_led_d && (div_d >= DivHalf);
      led_dt_d  = act_led_d && shreg_d[SEG_BITS-1];
    end
    if (state_d == StLatch) begin
      seg_en_d = !act_led_d;
      led_en_d = act_led_d;
    end
    seg_ack_d = (state_d == StLoad) && !act_led_d;
    led_ack_d = (state_d == StLoad) && act_led_d;
    busy_d    = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= StIdle;
      act_led_q  <= 1'b0;
      last_led_q <= 1'b1;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      seg_clk_q  <= 1'b0;
      seg_dt_q   <= 1'b0;
      seg_en_q   <= 1'b0;
      led_clk_q  <= 1'b0;
      led_dt_q   <= 1'b0;
      led_en_q   <= 1'b0;
      clr_q      <= 1'b0;
      seg_ack_q  <= 1'b0;
      led_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_led_q  <= act_led_d;
      last_led_q <= last_led_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      seg_clk_q  <= seg_clk_d;
      seg_dt_q   <= seg_dt_d;
      seg_en_q   <= seg_en_d;
      led_clk_q  <= led_clk_d;
      led_dt_q   <= led_dt_d;
      led_en_q   <= led_en_d;
      clr_q      <= 1'b1;
      seg_ack_q  <= seg_ack_d;
      led_ack_q  <= led_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign SEGCLK      = seg_clk_q;
  assign SEGDT       = seg_dt_q;
  assign SEGEN       = seg_en_q;
  assign SEGCLR      = clr_q;
  assign LEDCLK      = led_clk_q;
  assign LEDDT       = led_dt_q;
  assign LEDEN       = led_en_q;
  assign LEDCLR      = clr_q;
  assign bus.seg_ack = seg_ack_q;
  assign bus.led_ack = led_ack_q;
  assign bus.busy    = busy_q;

endmodule
